// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: operand widths, FSM state encoding, queued command.
// No logic, no latency.
// No flow control of its own; used by alu_cmd_fifo and alu_issue_ctrl.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rt;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue between the accept port and the issue FSM; registered storage, head visible combinationally.
// Latency: an entry pushed at edge N is poppable from edge N+1.
// Backpressure: a push while full and a pop while empty are ignored; full/empty come from registered state.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic push,
    input  cmd_t push_dat,
    input  logic pop,
    output cmd_t pop_dat,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Queues ALU commands, issues them one at a time to an external combinational ALU and returns responses in order.
// Latency: accept at edge N -> ALU operands at N+1 -> response valid after N+2; one response per 2 cycles.
// Backpressure: cmd_ready_o drops when the queue is full; a stalled response is held stable until rsp_ready_i.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [OP_W-1:0]   cmd_opcode_i,
    input  logic [DATA_W-1:0] cmd_rs_i,
    input  logic [DATA_W-1:0] cmd_rt_i,
    output logic [OP_W-1:0]   alu_opcode_o,
    output logic [DATA_W-1:0] alu_rs_o,
    output logic [DATA_W-1:0] alu_rt_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
    output logic [OP_W-1:0]   rsp_opcode_o,
    output logic [CNT_W-1:0]  issue_cnt_o,
    output logic              busy_o
);

    state_e state_q;
    cmd_t   cmd_in;
    cmd_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;

    assign cmd_in      = '{opcode: cmd_opcode_i, rs: cmd_rs_i, rt: cmd_rt_i};
    assign cmd_ready_o = !fifo_full;
    assign push        = cmd_valid_i && !fifo_full;
    assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;

    alu_cmd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (push),
        .push_dat(cmd_in),
        .pop     (pop),
        .pop_dat (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // In HOLD, rsp_valid_o is always high, so rsp_ready_i alone completes the handshake.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            ST_IDLE: pop = !fifo_empty;
            ST_HOLD: pop = rsp_ready_i && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            alu_opcode_o <= '0;
            alu_rs_o     <= '0;
            alu_rt_o     <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            rsp_opcode_o <= '0;
            issue_cnt_o  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        alu_opcode_o <= head.opcode;
                        alu_rs_o     <= head.rs;
                        alu_rt_o     <= head.rt;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rsp_result_o <= alu_result_i;
                    rsp_zero_o   <= alu_zero_i;
                    rsp_opcode_o <= alu_opcode_o;
                    rsp_valid_o  <= 1'b1;
                    state_q      <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        issue_cnt_o <= issue_cnt_o + CNT_W'(1);
                        if (pop) begin
                            alu_opcode_o <= head.opcode;
                            alu_rs_o     <= head.rs;
                            alu_rt_o     <= head.rt;
                            state_q      <= ST_ISSUE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an XOR ALU stub; CNT_W is 4 so counter wrap is reachable.
module tb_alu_issue_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b1;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [2:0] cmd_opcode_i;
    logic [7:0] cmd_rs_i;
    logic [7:0] cmd_rt_i;
    logic [2:0] alu_opcode_o;
    logic [7:0] alu_rs_o;
    logic [7:0] alu_rt_o;
    logic [7:0] alu_result_i;
    logic       alu_zero_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_result_o;
    logic       rsp_zero_o;
    logic [2:0] rsp_opcode_o;
    logic [3:0] issue_cnt_o;
    logic       busy_o;

    int n_vec = 0;
    int n_err = 0;

    alu_issue_ctrl #(.FIFO_DEPTH(4), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_opcode_i(cmd_opcode_i), .cmd_rs_i(cmd_rs_i), .cmd_rt_i(cmd_rt_i),
        .alu_opcode_o(alu_opcode_o), .alu_rs_o(alu_rs_o), .alu_rt_o(alu_rt_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o), .rsp_opcode_o(rsp_opcode_o),
        .issue_cnt_o(issue_cnt_o), .busy_o(busy_o)
    );

    assign alu_result_i = alu_rs_o ^ alu_rt_o;
    assign alu_zero_i   = (alu_result_i == 8'h00);

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] rs, input logic [7:0] rt);
        cmd_opcode_i = op;
        cmd_rs_i     = rs;
        cmd_rt_i     = rt;
        cmd_valid_i  = 1'b1;
    endtask

    task automatic test_reset();
        cmd_valid_i = 1'b0; rsp_ready_i = 1'b0;
        cmd_opcode_i = 3'd0; cmd_rs_i = 8'h00; cmd_rt_i = 8'h00;
        #1 rst_n_i = 1'b0;
        #2;
        n_vec++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %h want 1", cmd_ready_o); end
        n_vec++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %h want 0", rsp_valid_o); end
        n_vec++; if (rsp_result_o !== 8'h00) begin n_err++; $display("FAIL rst_rsp_result: got %h want 00", rsp_result_o); end
        n_vec++; if (rsp_zero_o !== 1'b0) begin n_err++; $display("FAIL rst_rsp_zero: got %h want 0", rsp_zero_o); end
        n_vec++; if (rsp_opcode_o !== 3'd0) begin n_err++; $display("FAIL rst_rsp_opcode: got %h want 0", rsp_opcode_o); end
        n_vec++; if (alu_opcode_o !== 3'd0) begin n_err++; $display("FAIL rst_alu_opcode: got %h want 0", alu_opcode_o); end
        n_vec++; if (alu_rs_o !== 8'h00) begin n_err++; $display("FAIL rst_alu_rs: got %h want 00", alu_rs_o); end
        n_vec++; if (alu_rt_o !== 8'h00) begin n_err++; $display("FAIL rst_alu_rt: got %h want 00", alu_rt_o); end
        n_vec++; if (issue_cnt_o !== 4'd0) begin n_err++; $display("FAIL rst_cnt: got %h want 0", issue_cnt_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %h want 0", busy_o); end
        #20 rst_n_i = 1'b1;
        tick();
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy_after: got %h want 0", busy_o); end
    endtask

    task automatic test_single_op();
        drive(3'd0, 8'h55, 8'hAA);
        n_vec++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL single_ready: got %h want 1", cmd_ready_o); end
        tick();
        cmd_valid_i = 1'b0;
        n_vec++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_n0: got %h want 0", rsp_valid_o); end
        tick();
        n_vec++; if (alu_rs_o !== 8'h55 || alu_rt_o !== 8'hAA) begin n_err++; $display("FAIL single_alu_ops: got %h/%h want 55/aa", alu_rs_o, alu_rt_o); end
        n_vec++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_n1: got %h want 0", rsp_valid_o); end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy: got %h want 1", busy_o); end
        tick();
        n_vec++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid_n2: got %h want 1", rsp_valid_o); end
        n_vec++; if (rsp_result_o !== 8'hFF) begin n_err++; $display("FAIL single_result: got %h want ff", rsp_result_o); end
        n_vec++; if (rsp_zero_o !== 1'b0) begin n_err++; $display("FAIL single_zero: got %h want 0", rsp_zero_o); end
        n_vec++; if (rsp_opcode_o !== 3'd0) begin n_err++; $display("FAIL single_opcode: got %h want 0", rsp_opcode_o); end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        n_vec++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_clr: got %h want 0", rsp_valid_o); end
        n_vec++; if (issue_cnt_o !== 4'd1) begin n_err++; $display("FAIL single_cnt: got %h want 1", issue_cnt_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL single_idle: got %h want 0", busy_o); end
    endtask

    task automatic test_zero_flag();
        drive(3'd7, 8'hFF, 8'hFF);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        n_vec++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL zero_valid: got %h want 1", rsp_valid_o); end
        n_vec++; if (rsp_result_o !== 8'h00) begin n_err++; $display("FAIL zero_result: got %h want 00", rsp_result_o); end
        n_vec++; if (rsp_zero_o !== 1'b1) begin n_err++; $display("FAIL zero_flag: got %h want 1", rsp_zero_o); end
        n_vec++; if (rsp_opcode_o !== 3'd7) begin n_err++; $display("FAIL zero_opcode: got %h want 7", rsp_opcode_o); end
        tick();
        n_vec++; if (rsp_valid_o !== 1'b1 || rsp_zero_o !== 1'b1 || rsp_opcode_o !== 3'd7) begin n_err++; $display("FAIL zero_hold: got v%h z%h op%h want v1 z1 op7", rsp_valid_o, rsp_zero_o, rsp_opcode_o); end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        n_vec++; if (issue_cnt_o !== 4'd2) begin n_err++; $display("FAIL zero_cnt: got %h want 2", issue_cnt_o); end
        n_vec++; if (alu_rs_o !== 8'hFF || alu_opcode_o !== 3'd7) begin n_err++; $display("FAIL zero_alu_keep: got %h/%h want ff/7", alu_rs_o, alu_opcode_o); end
    endtask

    task automatic test_backpressure();
        logic [7:0] rs_t  [6];
        logic [7:0] exp_t [5];
        logic       exp_rdy;
        int         got;
        int         last;
        rs_t  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_t = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(3'(i + 1), rs_t[i], 8'(i + 1));
            exp_rdy = (i < 5);
            n_vec++; if (cmd_ready_o !== exp_rdy) begin n_err++; $display("FAIL bp_ready_%0d: got %h want %h", i, cmd_ready_o, exp_rdy); end
            tick();
        end
        cmd_valid_i = 1'b0;
        n_vec++; if (cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_full: got %h want 0", cmd_ready_o); end
        rsp_ready_i = 1'b1;
        got  = 0;
        last = 0;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            if (rsp_valid_o === 1'b1) begin
                n_vec++; if (rsp_result_o !== exp_t[got] || rsp_opcode_o !== 3'(got + 1)) begin n_err++; $display("FAIL bp_rsp_%0d: got %h/%h want %h/%h", got, rsp_result_o, rsp_opcode_o, exp_t[got], 3'(got + 1)); end
                if (got > 0) begin
                    n_vec++; if (cyc - last !== 2) begin n_err++; $display("FAIL bp_gap_%0d: got %0d want 2", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
            tick();
        end
        rsp_ready_i = 1'b0;
        n_vec++; if (got !== 5) begin n_err++; $display("FAIL bp_count: got %0d want 5", got); end
        n_vec++; if (issue_cnt_o !== 4'd7) begin n_err++; $display("FAIL bp_cnt: got %h want 7", issue_cnt_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %h want 0", busy_o); end
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_r [3];
        logic [2:0] exp_o [3];
        int         got;
        exp_r = '{8'h26, 8'hFE, 8'h00};
        exp_o = '{3'd2, 3'd3, 3'd4};
        rsp_ready_i = 1'b0;
        drive(3'd0, 8'hA0, 8'h0F); tick();
        drive(3'd2, 8'h12, 8'h34); tick();
        drive(3'd3, 8'hFF, 8'h01); tick();
        cmd_valid_i = 1'b0;
        n_vec++; if (dut.u_fifo.level !== 3'd2) begin n_err++; $display("FAIL pp_level_pre: got %0d want 2", dut.u_fifo.level); end
        n_vec++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 8'hAF) begin n_err++; $display("FAIL pp_first: got v%h r%h want v1 raf", rsp_valid_o, rsp_result_o); end
        drive(3'd4, 8'h5A, 8'h5A);
        rsp_ready_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        n_vec++; if (dut.u_fifo.level !== 3'd2) begin n_err++; $display("FAIL pp_level_post: got %0d want 2", dut.u_fifo.level); end
        got = 0;
        for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
            if (rsp_valid_o === 1'b1) begin
                n_vec++; if (rsp_result_o !== exp_r[got] || rsp_opcode_o !== exp_o[got]) begin n_err++; $display("FAIL pp_rsp_%0d: got %h/%h want %h/%h", got, rsp_result_o, rsp_opcode_o, exp_r[got], exp_o[got]); end
                got++;
            end
            tick();
        end
        rsp_ready_i = 1'b0;
        n_vec++; if (got !== 3) begin n_err++; $display("FAIL pp_count: got %0d want 3", got); end
        n_vec++; if (issue_cnt_o !== 4'd11) begin n_err++; $display("FAIL pp_cnt: got %0d want 11", issue_cnt_o); end
    endtask

    task automatic test_reset_mid();
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(3'd5, 8'(i + 1), 8'h00);
            tick();
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        n_vec++; if (dut.u_fifo.level !== 3'd3 || rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rm_pre: got lvl%0d v%h want lvl3 v0", dut.u_fifo.level, rsp_valid_o); end
        #2 rst_n_i = 1'b0;
        #1;
        n_vec++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL rm_ready_busy: got %h/%h want 1/0", cmd_ready_o, busy_o); end
        n_vec++; if (rsp_valid_o !== 1'b0 || rsp_result_o !== 8'h00 || rsp_zero_o !== 1'b0 || rsp_opcode_o !== 3'd0) begin n_err++; $display("FAIL rm_rsp: got v%h r%h z%h op%h want all 0", rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_opcode_o); end
        n_vec++; if (alu_opcode_o !== 3'd0 || alu_rs_o !== 8'h00 || alu_rt_o !== 8'h00) begin n_err++; $display("FAIL rm_alu: got %h/%h/%h want 0/0/0", alu_opcode_o, alu_rs_o, alu_rt_o); end
        n_vec++; if (issue_cnt_o !== 4'd0) begin n_err++; $display("FAIL rm_cnt: got %h want 0", issue_cnt_o); end
        #2 rst_n_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_vec++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL rm_stale_%0d: got v%h b%h want 0/0", c, rsp_valid_o, busy_o); end
        end
    endtask

    task automatic test_cnt_wrap();
        logic [7:0] rs;
        logic [7:0] rt;
        logic [7:0] exp_res;
        rt = 8'h3C;
        for (int i = 0; i < 17; i++) begin
            rs      = 8'(i * 13);
            exp_res = rs ^ rt;
            drive(3'(i), rs, rt);
            tick();
            cmd_valid_i = 1'b0;
            tick();
            tick();
            n_vec++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== exp_res || rsp_opcode_o !== 3'(i)) begin n_err++; $display("FAIL wrap_rsp_%0d: got v%h r%h op%h want v1 r%h op%h", i, rsp_valid_o, rsp_result_o, rsp_opcode_o, exp_res, 3'(i)); end
            rsp_ready_i = 1'b1;
            tick();
            rsp_ready_i = 1'b0;
            if (i == 15) begin
                n_vec++; if (issue_cnt_o !== 4'd0) begin n_err++; $display("FAIL wrap_cnt16: got %0d want 0", issue_cnt_o); end
            end
        end
        n_vec++; if (issue_cnt_o !== 4'd1) begin n_err++; $display("FAIL wrap_cnt17: got %0d want 1", issue_cnt_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_op();
        test_zero_flag();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, min 2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the issued-operation counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk_i  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid_i  input  1  command offered.
REQ-007 SHALL have port cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-008 SHALL have port cmd_opcode_i  input  3  ALU opcode.
REQ-009 SHALL have port cmd_rs_i / cmd_rt_i  input  8 each  ALU operands.
REQ-010 SHALL have port alu_opcode_o  output  3, and alu_rs_o / alu_rt_o  output  8 each, all registered, driving the ALU.
REQ-011 SHALL have port alu_result_i  input  8, and alu_zero_i  input  1, combinational ALU outputs.
REQ-012 SHALL have port rsp_valid_o  output  1  response available.
REQ-013 SHALL have port rsp_ready_i  input  1  consumer accepts response.
REQ-014 SHALL have port rsp_result_o  output  8, rsp_zero_o  output  1, rsp_opcode_o  output  3  captured response.
REQ-015 SHALL have port issue_cnt_o  output  CNT_W  completed-response count; busy_o  output  1  high unless IDLE with empty FIFO.

Function
REQ-016 SHALL accept a command on a rising edge where cmd_valid_i and cmd_ready_o are both high, pushing {opcode, rs, rt} into the FIFO.
REQ-017 SHALL drive cmd_ready_o = FIFO not full, from registered state only; a push is refused when full even if a pop occurs in the same cycle.
REQ-018 SHALL implement FSM states IDLE, ISSUE, HOLD.
REQ-019 IDLE: if FIFO non-empty, pop the head into the alu_* registers and go to ISSUE; otherwise remain.
REQ-020 ISSUE: on the next edge capture alu_result_i, alu_zero_i and the held opcode into the rsp_* registers, set rsp_valid_o, go to HOLD.
REQ-021 HOLD: hold all rsp_* stable while rsp_valid_o high and rsp_ready_i low; on handshake clear rsp_valid_o, increment issue_cnt_o, and either pop the next entry (go ISSUE) or go IDLE if the FIFO is empty.
REQ-022 Latency: command accepted at edge N into an empty FIFO in IDLE -> alu_* loaded at edge N+1 -> rsp_valid_o high after edge N+2.
REQ-023 Throughput with rsp_ready_i tied high: one response every 2 cycles.
REQ-024 alu_* outputs SHALL keep the last issued operation between operations (no glitching to zero).
REQ-025 Responses SHALL be returned in command acceptance order; no command dropped or duplicated.
REQ-026 Simultaneous push and pop on a non-full FIFO SHALL both take effect; occupancy is unchanged.
REQ-027 Pop on the same edge that pushes into an empty FIFO SHALL NOT occur; the new entry is popped on the following edge.
REQ-028 issue_cnt_o SHALL wrap from 2^CNT_W-1 to 0 without other effect.
REQ-029 The block SHALL NOT interpret opcode values; all 8 opcodes are passed through unchanged.

Reset
REQ-030 Asserting rst_n_i low at any time SHALL immediately force: state IDLE, FIFO empty, cmd_ready_o 1 (after FIFO clear), rsp_valid_o 0, rsp_result_o 0, rsp_zero_o 0, rsp_opcode_o 0, alu_opcode_o 0, alu_rs_o 0, alu_rt_o 0, issue_cnt_o 0, busy_o 0.
REQ-031 In-flight and queued commands SHALL be discarded on reset; no response is produced for them after release.
REQ-032 Reset release SHALL be synchronised externally; first accept possible on the first edge after release.

Structure
REQ-033 Shared package alu_pkg SHALL hold DATA_W=8, OP_W=3, the FSM state enum, and the command struct {opcode, rs, rt}.
REQ-034 The FIFO SHALL be a sub-module alu_cmd_fifo (parameter FIFO_DEPTH; push/pop/full/empty, registered storage, async active-low reset).

Verification (bench ALU stub: result = rs XOR rt, zero = result==0)
REQ-035 Single op: opcode 000, rs 0x55, rt 0xAA at edge N -> rsp_valid_o after N+2, rsp_result_o 0xFF, rsp_zero_o 0, rsp_opcode_o 000, issue_cnt_o 1 after handshake.
REQ-036 Zero flag: rs 0xFF, rt 0xFF, opcode 111 -> rsp_result_o 0x00, rsp_zero_o 1.
REQ-037 Backpressure/full: rsp_ready_i low, push 6 commands -> 5 accepted (1 in HOLD + 4 queued), cmd_ready_o 0; release ready -> 5 responses in order, responses 2 cycles apart.
REQ-038 Reset mid-operation: 3 commands queued, assert rst_n_i during ISSUE -> all outputs at REQ-030 values; after release no stale response appears.
REQ-039 Counter wrap (CNT_W=4): 17 completed responses -> issue_cnt_o reads 1.
REQ-040 Simultaneous push/pop with 2 entries queued -> occupancy stays 2, order preserved.
